// File: rtl/i2c_target_if.sv
// Local-side handshake between the I2C target and the logic that consumes
// written bytes and supplies bytes for reads.
interface i2c_target_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_req;
    logic                  busy;
    logic                  nack;

    // Local logic: supplies tx_data, observes everything else
    modport master (
        input  rx_data, rx_valid, tx_req, busy, nack,
        output tx_data
    );

    // Target: produces the byte stream and status, consumes tx_data
    modport slave (
        output rx_data, rx_valid, tx_req, busy, nack,
        input  tx_data
    );
endinterface

// File: rtl/i2c_target.sv
// Single-address I2C target. Synchronises SCL/SDA, detects START/STOP and
// clock edges, matches OWN_ADDR, receives write bytes and serialises read
// bytes MSB first. SDA is open-drain: only ever pulled low or released.
module i2c_target #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] OWN_ADDR   = 7'h42
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire         sda,
    input  logic        scl,
    i2c_target_if.slave lcl
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
    } state_t;

    state_t                state;
    logic                  scl_s1, scl_s2, scl_d;
    logic                  sda_s1, sda_s2, sda_d;
    logic                  rise_ev, fall_ev, start_ev, stop_ev;
    logic [DATA_WIDTH-1:0] shifter;
    logic [3:0]            bit_cnt;
    logic [1:0]            ack_step;
    logic                  rw;
    logic                  sda_low;

    assign sda = sda_low ? 1'b0 : 1'bz;

    // Two-stage synchronisers plus one delay stage for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Registered bus events; sda_d lines up with the sample that caused them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise_ev  <= 1'b0;
            fall_ev  <= 1'b0;
            start_ev <= 1'b0;
            stop_ev  <= 1'b0;
        end else begin
            rise_ev  <= scl_s2 & ~scl_d;
            fall_ev  <= ~scl_s2 & scl_d;
            start_ev <= scl_s2 & sda_d & ~sda_s2;
            stop_ev  <= scl_s2 & ~sda_d & sda_s2;
        end
    end

    // Protocol FSM with registered SDA driver and local-side outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shifter     <= '0;
            bit_cnt     <= '0;
            ack_step    <= '0;
            rw          <= 1'b0;
            sda_low     <= 1'b0;
            lcl.rx_data <= '0;
            lcl.rx_valid <= 1'b0;
            lcl.tx_req  <= 1'b0;
            lcl.busy    <= 1'b0;
            lcl.nack    <= 1'b0;
        end else begin
            lcl.rx_valid <= 1'b0;
            lcl.tx_req   <= 1'b0;
            lcl.nack     <= 1'b0;
            if (start_ev) begin
                sda_low  <= 1'b0;
                lcl.busy <= 1'b0;
                bit_cnt  <= '0;
                state    <= ADDR;
            end else if (stop_ev) begin
                sda_low  <= 1'b0;
                lcl.busy <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        sda_low <= 1'b0;
                    end
                    ADDR: begin
                        if (rise_ev) begin
                            shifter <= {shifter[DATA_WIDTH-2:0], sda_d};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (shifter[ADDR_WIDTH-1:0] == OWN_ADDR) begin
                                    lcl.busy   <= 1'b1;
                                    rw         <= sda_d;
                                    lcl.tx_req <= sda_d;
                                    ack_step   <= 2'd0;
                                    state      <= ADDR_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    ADDR_ACK, WRITE_ACK: begin
                        if (fall_ev && ack_step == 2'd0) begin
                            sda_low  <= 1'b1;
                            ack_step <= 2'd1;
                        end else if (rise_ev && ack_step == 2'd1) begin
                            ack_step <= 2'd2;
                        end else if (fall_ev && ack_step == 2'd2) begin
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw) begin
                                // First read byte goes out on the same fall that ends the ACK
                                shifter <= lcl.tx_data;
                                sda_low <= ~lcl.tx_data[DATA_WIDTH-1];
                                state   <= READ;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (rise_ev) begin
                            shifter <= {shifter[DATA_WIDTH-2:0], sda_d};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                lcl.rx_data  <= {shifter[DATA_WIDTH-2:0], sda_d};
                                lcl.rx_valid <= 1'b1;
                                ack_step     <= 2'd0;
                                state        <= WRITE_ACK;
                            end
                        end
                    end
                    READ: begin
                        if (rise_ev) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (fall_ev) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low  <= 1'b0;
                                ack_step <= 2'd0;
                                state    <= READ_ACK;
                            end else begin
                                shifter <= {shifter[DATA_WIDTH-2:0], 1'b0};
                                sda_low <= ~shifter[DATA_WIDTH-2];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (rise_ev && ack_step == 2'd0) begin
                            if (!sda_d) begin
                                lcl.tx_req <= 1'b1;
                                ack_step   <= 2'd1;
                            end else begin
                                lcl.nack <= 1'b1;
                                state    <= IDLE;
                            end
                        end else if (fall_ev && ack_step == 2'd1) begin
                            shifter <= lcl.tx_data;
                            sda_low <= ~lcl.tx_data[DATA_WIDTH-1];
                            bit_cnt <= '0;
                            state   <= READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
